// File: rtl/load_pkg.sv
// -----------------------------------------------------------------------------
// load_pkg
// Shared definitions for the load alignment path.
//   - Size encodings carried on Bytes2Load (0 is treated as a word).
//   - FSM state encoding for load_align_unit.
//   - Helpers classifying an access by size and byte offset.
// Optional feature macro used by the consumers of this package:
//   LOAD_MISALIGN_EN
// -----------------------------------------------------------------------------
package load_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    RESP = 2'd3
  } state_t;

  // Size 0 has no access of its own; it behaves exactly like a word.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'd0) ? SZ_WORD : size;
  endfunction

  // Half on an odd byte, or word not on a word boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic [1:0] s;
    s = norm_size(size);
    return ((s == SZ_HALF) && offset[0]) ||
           ((s == SZ_WORD) && (offset != 2'd0));
  endfunction

  // Access needs bytes from the following word as well. A half at offset 1
  // is misaligned but still fits in one word (bits [23:8]).
  function automatic logic crosses_word(input logic [1:0] size,
                                        input logic [1:0] offset);
    logic [1:0] s;
    s = norm_size(size);
    return ((s == SZ_HALF) && (offset == 2'd3)) ||
           ((s == SZ_WORD) && (offset != 2'd0));
  endfunction

endpackage

// File: rtl/load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
// Combinational load data extraction: the inverse of the store byte merge.
// Forms {hi,lo}, shifts right by 8*offset, keeps the low 8/16/32 bits and
// sign- or zero-extends. i_sext has no effect on word loads.
// Ports:
//   i_lo     [31:0]  word at the aligned address
//   i_hi     [31:0]  following word (0 when only one word was read)
//   i_offset [1:0]   byte offset of the access within i_lo
//   i_size   [1:0]   1=byte, 2=half, 3 or 0=word
//   i_sext           1=sign-extend, 0=zero-extend
//   o_data   [31:0]  extended result
// -----------------------------------------------------------------------------
module load_extract
  import load_pkg::*;
(
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_data
);

  logic [63:0] w_cat;
  logic [63:0] w_shifted;
  logic        w_unused_hi;

  assign w_cat     = {i_hi, i_lo};
  assign w_shifted = w_cat >> {i_offset, 3'b000};
  // Upper half of the shifted pair never reaches the result.
  assign w_unused_hi = ^w_shifted[63:32];

  always_comb begin
    o_data = w_shifted[31:0];
    unique case (norm_size(i_size))
      SZ_BYTE: o_data = {{24{i_sext & w_shifted[7]}},  w_shifted[7:0]};
      SZ_HALF: o_data = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_data = w_shifted[31:0];
    endcase
  end

endmodule

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
// Accepts one load (lb/lbu/lh/lhu/lw) at a time from the MEM stage, reads the
// containing word(s) from data memory with any latency, extracts and extends
// the addressed data, and returns it over a valid/ready handshake.
//
// Handshakes: a transfer happens on a rising Clk edge where valid and ready
// are both high. Requests: ReqValid/ReqReady (ReqReady high only in IDLE).
// Memory: MemRdEn/MemAddr are held stable until MemRdValid is sampled high;
// MemRdValid outside a read state is ignored. Response: RspValid with
// RspData/RspErr held stable until RspReady.
//
// Optional feature: LOAD_MISALIGN_EN
//   defined   - misaligned loads are serviced; a word-crossing access reads
//               the aligned word (RD0) then the next word (RD1).
//   undefined - misaligned loads answer RspErr=1, RspData=0 without a read.
//
// Ports:
//   Clk, Reset           clock (rising), asynchronous active-high reset
//   ReqValid/ReqReady    request handshake
//   ReqAddr [ADDR_W]     byte address
//   Bytes2Load [2]       1=byte, 2=half, 3 or 0=word
//   SignExt              1=sign-extend byte/half
//   MemRdEn, MemAddr     memory read request, word-aligned address
//   MemRdData, MemRdValid memory read return
//   RspValid/RspReady    response handshake
//   RspData [DATA_W]     extended result
//   RspErr               misaligned access rejected
//   DbgState [2]         current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module load_align_unit
  import load_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [1:0]        Bytes2Load,
  input  logic              SignExt,
  output logic              MemRdEn,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [DATA_W-1:0] MemRdData,
  input  logic              MemRdValid,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspErr,
  output logic [1:0]        DbgState
);

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_sext;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_accept;
  logic                w_load_rsp;
  logic                w_rsp_err;
  logic [ADDR_W-1:0]   w_word_addr;
  logic [DATA_W-1:0]   w_ext_lo;
  logic [DATA_W-1:0]   w_ext_hi;
  logic [DATA_W-1:0]   w_ext_data;

`ifdef LOAD_MISALIGN_EN
  logic [DATA_W-1:0]   r_lo;
  logic                w_cap_lo;
`endif

  assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Next state, memory request and response-load decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load_rsp   = 1'b0;
    w_rsp_err    = 1'b0;
    MemRdEn      = 1'b0;
    MemAddr      = '0;
`ifdef LOAD_MISALIGN_EN
    w_cap_lo     = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (ReqValid) begin
          w_accept = 1'b1;
`ifdef LOAD_MISALIGN_EN
          w_next_state = RD0;
`else
          if (is_misaligned(Bytes2Load, ReqAddr[1:0])) begin
            // Rejected without touching memory.
            w_next_state = RESP;
            w_load_rsp   = 1'b1;
            w_rsp_err    = 1'b1;
          end else begin
            w_next_state = RD0;
          end
`endif
        end
      end
      RD0: begin
        MemRdEn = 1'b1;
        MemAddr = w_word_addr;
        if (MemRdValid) begin
`ifdef LOAD_MISALIGN_EN
          if (crosses_word(r_size, r_addr[1:0])) begin
            w_cap_lo     = 1'b1;
            w_next_state = RD1;
          end else begin
            w_load_rsp   = 1'b1;
            w_next_state = RESP;
          end
`else
          w_load_rsp   = 1'b1;
          w_next_state = RESP;
`endif
        end
      end
      RD1: begin
`ifdef LOAD_MISALIGN_EN
        MemRdEn = 1'b1;
        MemAddr = w_word_addr + ADDR_W'(4);  // wraps mod 2^ADDR_W
        if (MemRdValid) begin
          w_load_rsp   = 1'b1;
          w_next_state = RESP;
        end
`else
        w_next_state = IDLE;  // unreachable without the misaligned path
`endif
      end
      RESP: begin
        if (RspReady) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Extraction. In RD1 the live memory word is the high half of the pair and
  // the word captured in RD0 is the low half; otherwise the live word is low.
  // ---------------------------------------------------------------------------
`ifdef LOAD_MISALIGN_EN
  assign w_ext_lo = (r_state == RD1) ? r_lo : MemRdData;
  assign w_ext_hi = (r_state == RD1) ? MemRdData : '0;
`else
  assign w_ext_lo = MemRdData;
  assign w_ext_hi = '0;
`endif

  load_extract u_extract (
    .i_lo     (w_ext_lo),
    .i_hi     (w_ext_hi),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_sext   (r_sext),
    .o_data   (w_ext_data)
  );

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_size     <= 2'd0;
      r_sext     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr <= ReqAddr;
        r_size <= Bytes2Load;
        r_sext <= SignExt;
      end
      if (w_load_rsp) begin
        r_rsp_err  <= w_rsp_err;
        r_rsp_data <= w_rsp_err ? '0 : w_ext_data;
      end
    end
  end

`ifdef LOAD_MISALIGN_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lo <= '0;
    end else if (w_cap_lo) begin
      r_lo <= MemRdData;
    end
  end
`endif

  assign ReqReady = (r_state == IDLE);
  assign RspValid = (r_state == RESP);
  assign RspData  = r_rsp_data;
  assign RspErr   = r_rsp_err;
  assign DbgState = r_state;

endmodule

// File: tb/tb_load_align_unit.sv
// -----------------------------------------------------------------------------
// tb_load_align_unit
// Directed and randomized loads against a byte-level reference model of
// memory. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_load_align_unit;

  logic        Clk;
  logic        Reset;
  logic        ReqValid;
  logic        ReqReady;
  logic [31:0] ReqAddr;
  logic [1:0]  Bytes2Load;
  logic        SignExt;
  logic        MemRdEn;
  logic [31:0] MemAddr;
  logic [31:0] MemRdData;
  logic        MemRdValid;
  logic        RspValid;
  logic        RspReady;
  logic [31:0] RspData;
  logic        RspErr;
  logic [1:0]  DbgState;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mem_pre[logic [31:0]];

  // Directed table: word 0x0ACFFB19 at 0x200.
  logic [1:0]  d_off  [9] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0, 2'd0, 2'd2, 2'd0, 2'd0};
  logic [1:0]  d_size [9] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0};
  logic        d_sext [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] d_exp  [9] = '{32'h0000_0019, 32'hFFFF_FFFB, 32'h0000_00FB,
                              32'h0000_000A, 32'hFFFF_FB19, 32'h0000_FB19,
                              32'h0000_0ACF, 32'h0ACF_FB19, 32'h0ACF_FB19};

  load_align_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .ReqValid   (ReqValid),
    .ReqReady   (ReqReady),
    .ReqAddr    (ReqAddr),
    .Bytes2Load (Bytes2Load),
    .SignExt    (SignExt),
    .MemRdEn    (MemRdEn),
    .MemAddr    (MemAddr),
    .MemRdData  (MemRdData),
    .MemRdValid (MemRdValid),
    .RspValid   (RspValid),
    .RspReady   (RspReady),
    .RspData    (RspData),
    .RspErr     (RspErr),
    .DbgState   (DbgState)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------------------
  // Memory contents and reference model
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_pre.exists(a)) return mem_pre[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Assembles the result byte by byte from memory, then extends.
  task automatic ref_load(input logic [31:0] addr, input logic [1:0] size,
                          input logic sext, output logic [31:0] data,
                          output logic err, output int nreads,
                          output logic [31:0] rd0, output logic [31:0] rd1);
    int          nbytes;
    logic        mis;
    logic [31:0] a;
    logic [31:0] w;
    logic [31:0] last;
    nbytes = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : 4;
    mis    = ((nbytes == 2) && (addr % 2 != 0)) || ((nbytes == 4) && (addr % 4 != 0));
    data = 32'd0; err = 1'b0; nreads = 0; rd0 = 32'd0; rd1 = 32'd0;
`ifndef LOAD_MISALIGN_EN
    if (mis) begin
      err = 1'b1;
      return;
    end
`endif
    for (int k = 0; k < nbytes; k++) begin
      a = addr + 32'(k);
      w = mem_word(a & 32'hFFFF_FFFC);
      data = data | (((w >> (8 * (a % 4))) & 32'hFF) << (8 * k));
    end
    if (sext && (nbytes < 4) && data[8 * nbytes - 1])
      data = data | ~((32'd1 << (8 * nbytes)) - 32'd1);
    rd0    = addr & 32'hFFFF_FFFC;
    last   = (addr + 32'(nbytes - 1)) & 32'hFFFF_FFFC;
    rd1    = last;
    nreads = (last != rd0) ? 2 : 1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // One complete load: request, memory responder with wait states, response
  // with optional backpressure, handshake.
  // ---------------------------------------------------------------------------
  task automatic do_load(input string tag, input logic [31:0] addr,
                         input logic [1:0] size, input logic sext,
                         input int wait_n, input int bp_n,
                         input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] m_data;
    logic        m_err;
    int          nreads;
    logic [31:0] rd0;
    logic [31:0] rd1;
    int          n;
    int          waited;
    logic        done;
    int          exp_lat;
    ref_load(addr, size, sext, m_data, m_err, nreads, rd0, rd1);
    exp_q.delete();
    if (!m_err) begin
      exp_q.push_back(rd0);
      if (nreads == 2) exp_q.push_back(rd1);
    end

    @(negedge Clk);
    check({tag, "_req_ready"}, 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqAddr = addr; Bytes2Load = size; SignExt = sext;
    @(negedge Clk);
    ReqValid = 1'b0; ReqAddr = $urandom; Bytes2Load = 2'($urandom); SignExt = 1'($urandom);

    n = 0; waited = 0; done = 1'b0;
    while (!done && n < 60) begin
      MemRdValid = 1'b0;
      MemRdData  = $urandom;
      if (RspValid) begin
        done = 1'b1;
      end else begin
        check({tag, "_mem_rd_en"}, 32'(MemRdEn), 32'(exp_q.size() != 0));
        if (MemRdEn && exp_q.size() != 0) begin
          check({tag, "_mem_addr"}, MemAddr, exp_q[0]);
          if (waited < wait_n) begin
            waited++;
          end else begin
            MemRdValid = 1'b1;
            MemRdData  = mem_word(exp_q[0]);
            void'(exp_q.pop_front());
            waited = 0;
          end
        end
        n++;
        @(negedge Clk);
      end
    end
    check({tag, "_rsp_timeout"}, 32'(done), 32'd1);
    exp_lat = m_err ? 1 : 1 + nreads * (wait_n + 1);
    check({tag, "_latency"}, 32'(n + 1), 32'(exp_lat));
    check({tag, "_reads_left"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_data"}, RspData, exp_data);
    check({tag, "_err"}, 32'(RspErr), 32'(exp_err));
    check({tag, "_model_data"}, m_data, exp_data);
    check({tag, "_rden_resp"}, 32'(MemRdEn), 32'd0);
    check({tag, "_busy"}, 32'(ReqReady), 32'd0);

    for (int b = 0; b < bp_n; b++) begin
      ReqValid = 1'b1;
      ReqAddr  = 32'h300 + 32'($urandom_range(0, 15));
      Bytes2Load = 2'd3;
      RspReady = 1'b0;
      @(negedge Clk);
      check({tag, "_bp_valid"}, 32'(RspValid), 32'd1);
      check({tag, "_bp_data"}, RspData, exp_data);
      check({tag, "_bp_ready"}, 32'(ReqReady), 32'd0);
    end
    ReqValid = 1'b0;
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    check({tag, "_post_valid"}, 32'(RspValid), 32'd0);
    check({tag, "_post_ready"}, 32'(ReqReady), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] r_addr_v;
    logic [1:0]  r_size_v;
    logic        r_sext_v;
    logic [31:0] e_data;
    logic        e_err;
    int          e_n;
    logic [31:0] e_r0;
    logic [31:0] e_r1;

    mem_pre[32'h200] = 32'h0ACF_FB19;
    mem_pre[32'h100] = 32'h0ACF_FB19;
    mem_pre[32'h104] = 32'h1122_3344;

    Reset = 1'b1; ReqValid = 1'b0; ReqAddr = 32'd0; Bytes2Load = 2'd0;
    SignExt = 1'b0; MemRdData = 32'd0; MemRdValid = 1'b0; RspReady = 1'b0;
    #1;
    check("rst_req_ready", 32'(ReqReady), 32'd1);
    check("rst_mem_rd_en", 32'(MemRdEn), 32'd0);
    check("rst_mem_addr", MemAddr, 32'd0);
    check("rst_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_rsp_data", RspData, 32'd0);
    check("rst_rsp_err", 32'(RspErr), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;

    // Byte/half/word extraction from 0x0ACFFB19, zero-wait memory.
    for (int i = 0; i < 9; i++)
      do_load($sformatf("dir%0d", i), 32'h200 + 32'(d_off[i]), d_size[i],
              d_sext[i], 0, 0, d_exp[i], 1'b0);

    // Four wait states on the memory return.
    do_load("wait4", 32'h200, 2'd3, 1'b0, 4, 0, 32'h0ACF_FB19, 1'b0);

    // Response backpressure with a competing request held high.
    do_load("bp3", 32'h201, 2'd1, 1'b1, 0, 3, 32'hFFFF_FFFB, 1'b0);

    // Misaligned word at 0x101.
`ifdef LOAD_MISALIGN_EN
    do_load("mis_lw", 32'h101, 2'd3, 1'b0, 1, 1, 32'h440A_CFFB, 1'b0);
`else
    do_load("mis_lw", 32'h101, 2'd3, 1'b0, 1, 1, 32'h0000_0000, 1'b1);
`endif

    // Reset while a read is outstanding.
    @(negedge Clk);
    ReqValid = 1'b1; ReqAddr = 32'h200; Bytes2Load = 2'd3; SignExt = 1'b0;
    @(negedge Clk);
    ReqValid = 1'b0;
    check("rst_mid_pre_rden", 32'(MemRdEn), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("rst_mid_rden", 32'(MemRdEn), 32'd0);
    check("rst_mid_rsp_valid", 32'(RspValid), 32'd0);
    check("rst_mid_rsp_err", 32'(RspErr), 32'd0);
    check("rst_mid_mem_addr", MemAddr, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    MemRdValid = 1'b1;
    MemRdData  = 32'hDEAD_BEEF;
    @(negedge Clk);
    MemRdValid = 1'b0;
    check("rst_late_ready", 32'(ReqReady), 32'd1);
    check("rst_late_rden", 32'(MemRdEn), 32'd0);
    check("rst_late_rsp_valid", 32'(RspValid), 32'd0);
    do_load("rst_after_lw", 32'h200, 2'd3, 1'b0, 0, 0, 32'h0ACF_FB19, 1'b0);

    // Randomized loads, including addresses near the top of memory.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        r_addr_v = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else
        r_addr_v = 32'h300 + 32'($urandom_range(0, 63));
      r_size_v = 2'($urandom_range(0, 3));
      r_sext_v = 1'($urandom_range(0, 1));
      ref_load(r_addr_v, r_size_v, r_sext_v, e_data, e_err, e_n, e_r0, e_r1);
      do_load($sformatf("rnd%0d", i), r_addr_v, r_size_v, r_sext_v,
              $urandom_range(0, 3), $urandom_range(0, 2), e_data, e_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Read-side counterpart of the store byte-merge path: accepts a load request (lb/lbu/lh/lhu/lw) and reads the containing word(s) from data memory.
- Extracts the addressed byte/halfword/word and zero- or sign-extends it.
- Returns the result to the pipeline's MEM stage over a valid/ready handshake.
- Sits between the MEM-stage control and the data memory read port; tolerates variable memory latency.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory word / result width (fixed at 32 for this ISA).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ReqValid  in  1  load request valid.
- ReqReady  out  1  unit can accept a request.
- ReqAddr  in  32  byte address.
- Bytes2Load  in  2  size: 1=byte, 2=half, 3=word; 0 treated as word.
- SignExt  in  1  1=sign-extend (lb/lh), 0=zero-extend (lbu/lhu).
- MemRdEn  out  1  memory read request.
- MemAddr  out  32  word-aligned read address, bits [1:0] always 0.
- MemRdData  in  32  memory read data.
- MemRdValid  in  1  MemRdData valid this cycle.
- RspValid  out  1  result valid.
- RspReady  in  1  consumer accepts result.
- RspData  out  32  extended load result.
- RspErr  out  1  misaligned access rejected.

Behaviour:
- Reset (async): state=IDLE; ReqReady=1; MemRdEn=0; MemAddr=0; RspValid=0; RspData=0; RspErr=0. Reset mid-operation abandons any outstanding read; MemRdValid arriving after reset deassertion while in IDLE is ignored.
- States: IDLE, RD0, RD1, RESP.
- IDLE: ReqReady=1. On ReqValid&&ReqReady, latch ReqAddr, Bytes2Load, SignExt.
  - Aligned, or misaligned when the optional feature is on: go to RD0.
  - Misaligned with the optional feature off: go to RESP with RspErr=1, RspData=0, no memory read.
- Misaligned is defined as: half with addr[0]=1, or word with addr[1:0]!=0.
- RD0: MemRdEn=1; MemAddr={addr[31:2],2'b00}; both held stable until MemRdValid is sampled high. Capture lo=MemRdData.
  - If the access crosses a word boundary (half at offset 3, word at offset 1..3; feature on only): go to RD1.
  - Otherwise: go to RESP.
- RD1: MemRdEn=1; MemAddr=lo word address+4, wrapping mod 2^32. On MemRdValid, capture hi and go to RESP.
- MemRdEn is low in IDLE and RESP. MemRdValid outside RD0/RD1 is ignored.
- Extraction, little-endian byte lanes (offset k = bits [8k+7:8k]):
  - Form {hi,lo}, with hi=0 when only one read was made.
  - Shift right by 8*addr[1:0]; take the low 8/16/32 bits.
  - Sign-extend from bit 7/15 if SignExt, else zero-extend. SignExt is ignored for word loads.
- RESP: RspValid=1; RspData/RspErr registered and stable until RspValid&&RspReady, then IDLE.
  - ReqReady=0 in every state except IDLE, so there is no request overlap.
  - The next request can be accepted in the cycle after the response handshake.
- Latency:
  - Request accepted at cycle T; MemRdEn high from T+1.
  - If memory responds in the same cycle, RspValid rises the cycle after MemRdValid is sampled.
  - Aligned load, zero-wait memory: RspValid at T+2.
  - Error response: RspValid at T+1.

Optional Feature:
- Macro: LOAD_MISALIGN_EN.
- Defined: misaligned loads are serviced. Two reads (RD0 then RD1) are issued when the access crosses a word boundary; half at offset 1 uses a single read of bits [23:8]. RspErr is never asserted.
- Undefined: RD1 is not built; misaligned requests return RspErr=1, RspData=0 without touching memory.

Decomposition:
- Shared package load_pkg: size encodings SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3; state encoding IDLE/RD0/RD1/RESP; function is_misaligned(size, offset).
- Sub-module load_extract: combinational {hi,lo}/offset/size/SignExt to 32-bit result. It is the exact inverse of the store merge and is reusable by the bench as a reference model.

Test Plan:
- Byte loads from word 0x0ACFFB19, zero-wait memory:
  - lb offset0 -> 0x00000019.
  - lb offset1 -> 0xFFFFFFFB.
  - lbu offset1 -> 0x000000FB.
  - lb offset3 -> 0x0000000A.
  - RspValid at T+2 each.
- Half/word loads, same word:
  - lh offset0 -> 0xFFFFFB19.
  - lhu offset0 -> 0x0000FB19.
  - lh offset2 -> 0x00000ACF.
  - lw offset0 -> 0x0ACFFB19.
  - Bytes2Load=0 -> same as lw.
- Memory wait states: MemRdValid delayed 4 cycles -> MemRdEn and MemAddr held stable for 4 cycles; RspValid one cycle after MemRdValid.
- Backpressure: RspReady low 3 cycles -> RspData stable, ReqReady=0; a second ReqValid is not accepted until the cycle after the handshake.
- Misaligned lw at 0x101, mem[0x100]=0x0ACFFB19, mem[0x104]=0x11223344:
  - LOAD_MISALIGN_EN defined: reads 0x100 then 0x104; RspData=0x440ACFFB; RspErr=0.
  - LOAD_MISALIGN_EN undefined: RspErr=1, RspData=0, MemRdEn never asserted.
- Reset asserted in RD0 while MemRdEn=1 -> MemRdEn, RspValid, RspErr drop immediately (async); ReqReady=1 after release; a late MemRdValid is ignored; the next lw returns the correct data.
